// File: rtl/spatz_id_tracker_pkg.sv
// Shared types for the Spatz instruction-ID tracker: ID/register widths,
// per-ID usage record and retire-port naming.
package spatz_id_tracker_pkg;

    localparam int NrIds      = 4;
    localparam int NrRetPorts = 3;
    localparam int NrVregs    = 32;
    localparam int VregWidth  = $clog2(NrVregs);

    typedef logic [$clog2(NrIds)-1:0] spatz_id_t;
    typedef logic [VregWidth-1:0]     vreg_t;

    typedef struct packed {
        vreg_t vd;
        logic  use_vd;
        vreg_t vs1;
        logic  use_vs1;
        vreg_t vs2;
        logic  use_vs2;
    } id_entry_t;

    typedef enum logic [1:0] {
        RET_VFU   = 2'd0,
        RET_VLSU  = 2'd1,
        RET_VSLDU = 2'd2
    } ret_port_e;

endpackage

// File: rtl/spatz_lzc_alloc.sv
// Lowest-set-bit finder over the free-ID mask; valid_o is low when no ID is free.
module spatz_lzc_alloc
    import spatz_id_tracker_pkg::*;
#(
    parameter int Width    = 4,
    parameter int IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0]    free_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |free_i;
        // Scan downwards so the lowest free index is the last one written.
        for (int i = Width - 1; i >= 0; i--) begin
            if (free_i[i]) idx_o = IdxWidth'(i);
        end
    end

endmodule

// File: rtl/spatz_id_tracker.sv
// Instruction-ID allocator with per-ID vector-register usage tracking; blocks
// issue on RAW/WAR/WAW conflicts and frees IDs from multiple retire ports.
module spatz_id_tracker #(
    parameter int NrIds      = spatz_id_tracker_pkg::NrIds,
    parameter int NrVregs    = spatz_id_tracker_pkg::NrVregs,
    parameter int NrRetPorts = spatz_id_tracker_pkg::NrRetPorts,
    parameter int IdWidth    = $clog2(NrIds),
    parameter int VregWidth  = $clog2(NrVregs)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [VregWidth-1:0]          issue_vd_i,
    input  logic                          issue_use_vd_i,
    input  logic [VregWidth-1:0]          issue_vs1_i,
    input  logic                          issue_use_vs1_i,
    input  logic [VregWidth-1:0]          issue_vs2_i,
    input  logic                          issue_use_vs2_i,
    output logic [IdWidth-1:0]            issue_id_o,
    input  logic [NrRetPorts-1:0]         retire_valid_i,
    input  logic [NrRetPorts*IdWidth-1:0] retire_id_i,
    output logic [NrIds-1:0]              busy_o,
    output logic [NrVregs-1:0]            vreg_wr_pending_o,
    output logic                          stall_hazard_o,
    output logic                          idle_o,
    output logic                          err_o
);

    import spatz_id_tracker_pkg::*;

    localparam int CntWidth = $clog2(NrIds + 1);

    logic [NrIds-1:0]    busy_q, busy_d;
    id_entry_t           entry_q [NrIds];
    id_entry_t           entry_d [NrIds];
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [IdWidth-1:0]  alloc_id;
    logic                alloc_valid;
    id_entry_t           new_entry;
    logic                hazard;
    logic                accept;

    logic [NrIds-1:0]    ret_clr;
    logic [CntWidth-1:0] ret_cnt;
    logic                ret_err;
    logic [IdWidth-1:0]  ret_id;

    spatz_lzc_alloc #(
        .Width    (NrIds),
        .IdxWidth (IdWidth)
    ) i_alloc (
        .free_i  (~busy_q),
        .idx_o   (alloc_id),
        .valid_o (alloc_valid)
    );

    // Hazards look only at registered state, so same-cycle retires never unblock issue.
    always_comb begin
        new_entry.vd      = vreg_t'(issue_vd_i);
        new_entry.use_vd  = issue_use_vd_i;
        new_entry.vs1     = vreg_t'(issue_vs1_i);
        new_entry.use_vs1 = issue_use_vs1_i;
        new_entry.vs2     = vreg_t'(issue_vs2_i);
        new_entry.use_vs2 = issue_use_vs2_i;
        hazard = 1'b0;
        for (int i = 0; i < NrIds; i++) begin
            if (busy_q[i]) begin
                if (entry_q[i].use_vd) begin
                    if (new_entry.use_vs1 && new_entry.vs1 == entry_q[i].vd) hazard = 1'b1;
                    if (new_entry.use_vs2 && new_entry.vs2 == entry_q[i].vd) hazard = 1'b1;
                    if (new_entry.use_vd  && new_entry.vd  == entry_q[i].vd) hazard = 1'b1;
                end
                if (new_entry.use_vd) begin
                    if (entry_q[i].use_vs1 && entry_q[i].vs1 == new_entry.vd) hazard = 1'b1;
                    if (entry_q[i].use_vs2 && entry_q[i].vs2 == new_entry.vd) hazard = 1'b1;
                end
            end
        end
    end

    assign stall_hazard_o = issue_valid_i && hazard;
    assign issue_ready_o  = issue_valid_i && !hazard && alloc_valid;
    assign issue_id_o     = alloc_id;
    assign accept         = issue_ready_o;

    // A retire only counts when it names a busy ID not already cleared by a lower port.
    always_comb begin
        ret_clr = '0;
        ret_cnt = '0;
        ret_err = 1'b0;
        ret_id  = '0;
        for (int p = 0; p < NrRetPorts; p++) begin
            if (retire_valid_i[p]) begin
                ret_id = retire_id_i[p*IdWidth +: IdWidth];
                if (int'(ret_id) >= NrIds) begin
                    ret_err = 1'b1;
                end else if (!busy_q[ret_id] || ret_clr[ret_id]) begin
                    ret_err = 1'b1;
                end else begin
                    ret_clr[ret_id] = 1'b1;
                    ret_cnt         = ret_cnt + CntWidth'(1);
                end
            end
        end
    end

    always_comb begin
        busy_d  = busy_q & ~ret_clr;
        entry_d = entry_q;
        if (accept) begin
            busy_d[alloc_id]  = 1'b1;
            entry_d[alloc_id] = new_entry;
        end
        cnt_d = cnt_q + (accept ? CntWidth'(1) : CntWidth'(0)) - ret_cnt;
        err_d = err_q | ret_err;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NrIds; i++) entry_q[i] <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        vreg_wr_pending_o = '0;
        for (int r = 0; r < NrVregs; r++) begin
            for (int i = 0; i < NrIds; i++) begin
                if (busy_q[i] && entry_q[i].use_vd && entry_q[i].vd == vreg_t'(r))
                    vreg_wr_pending_o[r] = 1'b1;
            end
        end
    end

    assign busy_o = busy_q;
    assign idle_o = (cnt_q == '0);
    assign err_o  = err_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($countones(busy_q) == int'(cnt_q));
            assert (!issue_ready_o || issue_valid_i);
        end
    end
`endif

endmodule

// File: doc/spatz_id_tracker.md
Name: spatz_id_tracker

Overview:
- Parametrised instruction-ID allocator and vector-register hazard tracker between the Spatz decoder/controller and the execution units (VFU, VLSU, VSLDU).
- Generalises the fixed four-ID scheme to NrIds IDs and NrRetPorts retire ports.
- Records per-ID register usage and stalls issue on RAW, WAR and WAW conflicts.
- Frees IDs on unit responses.

Parameters:
- NrIds, 4, number of in-flight instruction IDs (2..16).
- NrVregs, 32, number of architectural vector registers.
- NrRetPorts, 3, number of retire ports (VFU, VLSU, VSLDU).
- IdWidth, $clog2(NrIds), ID width (derived).
- VregWidth, $clog2(NrVregs), register index width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- issue_valid_i  in  1  decoder presents an instruction
- issue_ready_o  out  1  instruction accepted this cycle
- issue_vd_i  in  VregWidth  destination register
- issue_use_vd_i  in  1  instruction writes vd
- issue_vs1_i  in  VregWidth  source 1
- issue_use_vs1_i  in  1  instruction reads vs1
- issue_vs2_i  in  VregWidth  source 2
- issue_use_vs2_i  in  1  instruction reads vs2
- issue_id_o  out  IdWidth  allocated ID; valid while issue_valid_i && issue_ready_o
- retire_valid_i  in  NrRetPorts  per-port retire strobe
- retire_id_i  in  NrRetPorts*IdWidth  per-port retired ID, port p at bits [p*IdWidth +: IdWidth]
- busy_o  out  NrIds  per-ID allocated flag
- vreg_wr_pending_o  out  NrVregs  register has an outstanding writer
- stall_hazard_o  out  1  issue blocked by a register conflict
- idle_o  out  1  no ID allocated
- err_o  out  1  sticky protocol error

Behaviour:
- State per ID: busy, vd, use_vd, vs1, use_vs1, vs2, use_vs2. Also an outstanding counter of width $clog2(NrIds+1).
- Reset (asynchronous, any cycle including mid-operation):
  - All busy cleared, counter = 0, err_o = 0, per-ID fields = 0.
  - Outputs after reset: issue_ready_o = 0 unless issue_valid_i is high with no hazard; issue_id_o = 0; busy_o = 0; vreg_wr_pending_o = 0; stall_hazard_o = 0; idle_o = 1.
- Hazards are computed only from registered state. Same-cycle retires never unblock the same-cycle issue.
  - RAW: use_vsX and vsX equals the vd of any busy ID with use_vd.
  - WAW: use_vd and vd equals the vd of any busy ID with use_vd.
  - WAR: use_vd and vd equals vs1/vs2 of any busy ID with the matching use bit.
- stall_hazard_o = issue_valid_i && any hazard.
- issue_ready_o = issue_valid_i && !stall_hazard_o && any ID not busy. Combinational, 0-cycle latency.
- Allocation: lowest-index non-busy ID, driven on issue_id_o combinationally. On the handshake, the ID becomes busy and its fields are captured at the next edge.
- Retire: for each port p with retire_valid_i[p], busy[retire_id_i[p]] is cleared at the next edge. Freed IDs are allocatable from the following cycle only.
- Simultaneous issue and retires in one cycle:
  - counter_next = counter + accepted − number of valid retires.
  - The allocated ID is never one being retired, because it was not busy.
- Error cases (any one sets err_o, which stays high until reset):
  - A retire of a non-busy ID is ignored.
  - Two ports retiring the same ID in one cycle clear it once.
- Full: all busy, so issue_ready_o = 0 and stall_hazard_o reflects only the register conflicts.
- idle_o = (counter == 0).
- vreg_wr_pending_o[r] = OR over busy IDs with use_vd and vd == r.
- Assertions (simulation only):
  - counter equals popcount(busy).
  - issue_ready_o implies issue_valid_i.

Decomposition:
- Shared package additions:
  - NrIds replaces NrParallelInstructions; spatz_id_t derives from it.
  - NrRetPorts constant.
  - id_entry_t struct (vd, use_vd, vs1, use_vs1, vs2, use_vs2).
  - Retire-port enum RET_VFU, RET_VLSU, RET_VSLDU.
- One sub-module, spatz_lzc_alloc: lowest-free-index finder with a valid output. Use the common lzc primitive where available.

Test Plan:
- Reset, then issue four independent instructions (vd = 1..4, no sources) on consecutive cycles:
  - issue_id_o = 0, 1, 2, 3.
  - Fifth request: issue_ready_o = 0, busy_o = 4'hF.
  - idle_o falls after the first issue.
- RAW stall: ID0 writes v5; next instruction reads vs1 = v5.
  - stall_hazard_o = 1 and ready = 0.
  - Retire ID0 on port 0: ready is still 0 that cycle and goes to 1 the next cycle, with issue_id_o = 0.
- WAR and WAW: ID1 reads v7; a new instruction writes v7, so it stalls. Same again with an outstanding writer of v7.
  - vreg_wr_pending_o[7] = 1 only in the writer case.
- Three retire ports retire IDs 0, 1, 2 in one cycle while an issue is accepted into ID3.
  - Next cycle busy_o = 4'b1000 and the counter = 1.
- Protocol errors:
  - Retire a free ID 2: err_o = 1 next cycle and busy_o is unchanged.
  - Two ports retire busy ID 1 together: cleared once, err_o stays 1.
- Reset asserted with three IDs busy:
  - busy_o = 0, idle_o = 1, err_o = 0 immediately (asynchronously).
  - After release, the first issue gets ID 0.
